elevator_scan_ctrl: RTL and testbench
=====================================

ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameter: N_FLOORS, 8, number of served floors (2..16).
REQ-002 Parameter: DOOR_CYCLES, 4, clock cycles door stays open per stop (>=1).
REQ-003 Derived localparam FW = clog2(N_FLOORS), floor index width.
REQ-004 Ports SHALL be:
clk  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
call_valid  in  1  one-cycle pulse registering a floor call.
call_floor  in  FW  floor index of call, sampled when call_valid=1.
current_floor  in  FW  floor sensor position.
floor_valid  in  1  car level with current_floor (stop permitted).
emergency_stop  in  1  level; halts car while high.
door_hold  in  1  level; obstruction, holds door open.
move_up  out  1  motor up command.
move_down  out  1  motor down command.
door_open  out  1  door command.
stopped  out  1  car not moving.
direction  out  1  travel preference, 1=up, 0=down.
pending  out  N_FLOORS  outstanding call bitmap, bit i = floor i.
state  out  3  FSM state, debug.

Function
REQ-005 FSM states/encodings: IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3, EMERGENCY=4; other codes unreachable, decode to IDLE.
REQ-006 Outputs Moore-decoded from registered state: move_up=(MOVE_UP), move_down=(MOVE_DOWN), door_open=(DOOR_OPEN), stopped=(IDLE|DOOR_OPEN|EMERGENCY).
REQ-007 Call registration: call_valid with call_floor<N_FLOORS sets pending[call_floor] at next edge; call_floor>=N_FLOORS ignored.
REQ-008 Call for current_floor while floor_valid=1 in IDLE: no pending bit set; FSM enters DOOR_OPEN next edge.
REQ-009 Call for current_floor in DOOR_OPEN: no pending bit set; door timer reloads to DOOR_CYCLES.
REQ-010 IDLE, pending==0: stay IDLE, direction unchanged.
REQ-011 IDLE, pending!=0 (SCAN): calls exist in direction -> move that way; else reverse direction and move; direction updated same edge as state change.
REQ-012 MOVE_UP/MOVE_DOWN: floor_valid=1 and pending[current_floor]=1 -> clear that bit, enter DOOR_OPEN, load timer=DOOR_CYCLES, same edge.
REQ-013 MOVE_UP with current_floor=N_FLOORS-1 and floor_valid=1 (or MOVE_DOWN at floor 0) -> IDLE; move_up never asserted at top, move_down never at floor 0.
REQ-014 MOVE_UP/MOVE_DOWN passing floor with no pending bit: continue, no stop.
REQ-015 Call arriving same cycle as a stop-clear for same floor: clear wins, bit ends 0.
REQ-016 DOOR_OPEN: timer decrements each cycle door_hold=0; holds and reloads to DOOR_CYCLES while door_hold=1; at timer==1 and door_hold=0 -> IDLE next edge; door open exactly DOOR_CYCLES cycles when unobstructed.
REQ-017 emergency_stop=1 in any state -> EMERGENCY next edge; highest priority over all transitions.
REQ-018 EMERGENCY: all motion and door outputs 0, stopped=1; calls still registered; pending retained.
REQ-019 emergency_stop returns 0 -> IDLE next edge; service resumes per REQ-011.

Reset
REQ-020 reset=0 SHALL asynchronously force: state=IDLE, pending=0, direction=1, timer=0; hence move_up=0, move_down=0, door_open=0, stopped=1.
REQ-021 Reset mid-move or mid-door SHALL discard all pending calls; release synchronous to clk, first transition on first edge after reset=1.

Structure
REQ-022 Shared package elevator_pkg SHALL hold state encodings and state type; N_FLOORS/DOOR_CYCLES stay module parameters.
REQ-023 One sub-module door_timer (load, hold, decrement, expire flag, width clog2(DOOR_CYCLES+1)) SHALL be instantiated; SCAN above/below masks combinational in top level.

Verification (N_FLOORS=8, DOOR_CYCLES=4)
REQ-024 Reset at floor 2, call floor 5 -> MOVE_UP; floor_valid at 3,4 no stop; at 5 DOOR_OPEN 4 cycles, pending=0, then IDLE.
REQ-025 At floor 4 dir up, calls 6 and 1 -> serves 6 first, reverses, serves 1; direction 1 then 0.
REQ-026 MOVE_UP toward 7, emergency_stop 3 cycles -> EMERGENCY next edge, all motion 0, pending[7] retained; release -> IDLE then MOVE_UP.
REQ-027 DOOR_OPEN with door_hold high 10 cycles -> door_open 10+4 cycles; call to same floor mid-door reloads timer, pending unchanged.
REQ-028 call_floor=9 (N_FLOORS=16 build: call 15 at top) -> ignored at 8 floors; at top floor move_up never asserted.
REQ-029 reset=0 asynchronously mid-MOVE_DOWN with pending=8'b0010_0101 -> outputs reset values immediately, pending=0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator SCAN controller.
// Holds the FSM state type and its fixed encodings so the controller, debug
// tooling and benches all agree on the values exposed on the state port.
package elevator_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_MOVE_UP   = 3'd1;
    localparam state_t ST_MOVE_DOWN = 3'd2;
    localparam state_t ST_DOOR_OPEN = 3'd3;
    localparam state_t ST_EMERGENCY = 3'd4;

endpackage

// File: rtl/door_timer.sv
// Door dwell timer.
// Counts down the cycles the door stays open at a stop.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset, clears the count
//   load    : reload the count to CYCLES (new stop or repeat call)
//   enable  : door is open, timer is running
//   hold    : obstruction, count is held at CYCLES while high
//   expired : last open cycle, door may close at the next edge
module door_timer #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    input  logic hold,
    output logic expired
);

    localparam int unsigned TW = $clog2(CYCLES + 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load || (enable && hold)) begin
            count_q <= TW'(CYCLES);
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // The count sits at CYCLES on the first open cycle, so reaching 1 unobstructed
    // means exactly CYCLES cycles have elapsed.
    assign expired = enable && !hold && (count_q == TW'(1));

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN (elevator algorithm) controller for a single car.
// Registers floor calls into a pending bitmap, keeps travelling in the current
// direction while calls remain ahead, reverses otherwise, stops at called floors
// and holds the door open for DOOR_CYCLES cycles (longer while obstructed).
//   clk, reset         : clock and asynchronous active-low reset
//   call_valid/floor   : one-cycle call request for a floor
//   current_floor      : floor sensor, floor_valid = car is level there
//   emergency_stop     : level, parks the car in EMERGENCY while high
//   door_hold          : level, obstruction keeps the door open
//   move_up/move_down  : motor commands
//   door_open, stopped : door command, car-not-moving indication
//   direction          : travel preference, 1 = up
//   pending, state     : outstanding call bitmap, FSM state for debug
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS    = 8,
    parameter int unsigned DOOR_CYCLES = 4,
    localparam int unsigned FW         = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                call_valid,
    input  logic [FW-1:0]       call_floor,
    input  logic [FW-1:0]       current_floor,
    input  logic                floor_valid,
    input  logic                emergency_stop,
    input  logic                door_hold,
    output logic                move_up,
    output logic                move_down,
    output logic                door_open,
    output logic                stopped,
    output logic                direction,
    output logic [N_FLOORS-1:0] pending,
    output logic [2:0]          state
);

    localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);

    state_t              state_q, state_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic                dir_q, dir_d;
    logic [N_FLOORS-1:0] above, below, call_bit, clear_bit, here_mask;
    logic                call_ok, call_here, here_pending;
    logic                timer_load, timer_expired;

    // Calls beyond the served range are dropped outright.
    assign call_ok      = call_valid && (32'(call_floor) < N_FLOORS);
    assign call_here    = call_ok && (call_floor == current_floor);
    assign here_mask    = N_FLOORS'(1) << current_floor;
    assign here_pending = |(pending_q & here_mask);

    // SCAN masks: outstanding calls strictly above / below the car.
    always_comb begin
        above = '0;
        below = '0;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            above[i] = pending_q[i] && (i > int'(current_floor));
            below[i] = pending_q[i] && (i < int'(current_floor));
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        timer_load = 1'b0;
        call_bit   = call_ok ? (N_FLOORS'(1) << call_floor) : '0;
        clear_bit  = '0;

        if (emergency_stop) begin
            state_d = ST_EMERGENCY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (call_here && floor_valid) begin
                        // Already at the called floor: just open, nothing to remember.
                        call_bit   = '0;
                        state_d    = ST_DOOR_OPEN;
                        timer_load = 1'b1;
                    end else if (floor_valid && here_pending) begin
                        // Call left behind at this floor (e.g. logged during an emergency).
                        clear_bit  = here_mask;
                        state_d    = ST_DOOR_OPEN;
                        timer_load = 1'b1;
                    end else if (|above && (dir_q || ~|below)) begin
                        state_d = ST_MOVE_UP;
                        dir_d   = 1'b1;
                    end else if (|below) begin
                        state_d = ST_MOVE_DOWN;
                        dir_d   = 1'b0;
                    end
                end
                ST_MOVE_UP, ST_MOVE_DOWN: begin
                    if (floor_valid && here_pending) begin
                        // Clearing after the OR lets the stop win over a same-cycle call.
                        clear_bit  = here_mask;
                        state_d    = ST_DOOR_OPEN;
                        timer_load = 1'b1;
                    end else if (floor_valid && (state_q == ST_MOVE_UP)
                                 && (current_floor == TOP_FLOOR)) begin
                        state_d = ST_IDLE;
                    end else if (floor_valid && (state_q == ST_MOVE_DOWN)
                                 && (current_floor == '0)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DOOR_OPEN: begin
                    if (call_here) begin
                        call_bit   = '0;
                        timer_load = 1'b1;
                    end else if (timer_expired) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EMERGENCY: state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end

        pending_d = (pending_q | call_bit) & ~clear_bit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            dir_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dir_q     <= dir_d;
        end
    end

    door_timer #(
        .CYCLES (DOOR_CYCLES)
    ) u_door_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .enable  (state_q == ST_DOOR_OPEN),
        .hold    (door_hold),
        .expired (timer_expired)
    );

    // Unused encodings fall into the "stopped" group, matching their IDLE decode.
    assign move_up   = (state_q == ST_MOVE_UP);
    assign move_down = (state_q == ST_MOVE_DOWN);
    assign door_open = (state_q == ST_DOOR_OPEN);
    assign stopped   = !(move_up || move_down);
    assign direction = dir_q;
    assign pending   = pending_q;
    assign state     = state_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
module tb_elevator_scan_ctrl;

    localparam int NF = 8;
    localparam int DC = 4;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UP   = 3'd1;
    localparam logic [2:0] S_DN   = 3'd2;
    localparam logic [2:0] S_DOOR = 3'd3;
    localparam logic [2:0] S_EMG  = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic       call_valid, floor_valid, emergency_stop, door_hold;
    logic [2:0] call_floor, current_floor;
    logic       move_up, move_down, door_open, stopped, direction;
    logic [7:0] pending;
    logic [2:0] state;

    // Second build with 6 floors for the out-of-range call rule.
    logic       c6_valid;
    logic [2:0] c6_floor;
    logic       move_up6, move_down6, door_open6, stopped6, direction6;
    logic [5:0] pending6;
    logic [2:0] state6;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(.N_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
        .clk            (clk),
        .reset          (reset),
        .call_valid     (call_valid),
        .call_floor     (call_floor),
        .current_floor  (current_floor),
        .floor_valid    (floor_valid),
        .emergency_stop (emergency_stop),
        .door_hold      (door_hold),
        .move_up        (move_up),
        .move_down      (move_down),
        .door_open      (door_open),
        .stopped        (stopped),
        .direction      (direction),
        .pending        (pending),
        .state          (state)
    );

    elevator_scan_ctrl #(.N_FLOORS(6), .DOOR_CYCLES(DC)) dut6 (
        .clk            (clk),
        .reset          (reset),
        .call_valid     (c6_valid),
        .call_floor     (c6_floor),
        .current_floor  (3'd0),
        .floor_valid    (1'b0),
        .emergency_stop (1'b0),
        .door_hold      (1'b0),
        .move_up        (move_up6),
        .move_down      (move_down6),
        .door_open      (door_open6),
        .stopped        (stopped6),
        .direction      (direction6),
        .pending        (pending6),
        .state          (state6)
    );

    // Behavioural model of the car controller for the 8-floor build.
    logic [2:0] m_state = S_IDLE;
    logic [7:0] m_pend  = '0;
    logic       m_dir   = 1'b1;
    int         m_door  = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state <= S_IDLE;
            m_pend  <= '0;
            m_dir   <= 1'b1;
            m_door  <= 0;
        end else begin : step
            logic [2:0] ns;
            logic [7:0] np;
            logic       nd;
            int         ndoor;
            bit         calls_above, calls_below, ahead, behind, at_end;
            ns = m_state;
            np = m_pend;
            nd = m_dir;
            ndoor = m_door;
            calls_above = 0;
            calls_below = 0;
            for (int f = 0; f < NF; f++) begin
                if (m_pend[f] && f > int'(current_floor)) calls_above = 1;
                if (m_pend[f] && f < int'(current_floor)) calls_below = 1;
            end
            if (emergency_stop) begin
                ns = S_EMG;
                if (call_valid) np[call_floor] = 1'b1;
            end else if (m_state == S_IDLE) begin
                if (call_valid && floor_valid && call_floor == current_floor) begin
                    ns = S_DOOR;
                    ndoor = DC;
                end else begin
                    if (call_valid) np[call_floor] = 1'b1;
                    ahead  = m_dir ? calls_above : calls_below;
                    behind = m_dir ? calls_below : calls_above;
                    if (floor_valid && m_pend[current_floor]) begin
                        np[current_floor] = 1'b0;
                        ns = S_DOOR;
                        ndoor = DC;
                    end else if (ahead || behind) begin
                        if (!ahead) nd = !m_dir;
                        ns = nd ? S_UP : S_DN;
                    end
                end
            end else if (m_state == S_UP || m_state == S_DN) begin
                if (call_valid) np[call_floor] = 1'b1;
                at_end = (m_state == S_UP) ? (current_floor == 3'd7) : (current_floor == 3'd0);
                if (floor_valid && m_pend[current_floor]) begin
                    np[current_floor] = 1'b0;
                    ns = S_DOOR;
                    ndoor = DC;
                end else if (floor_valid && at_end) begin
                    ns = S_IDLE;
                end
            end else if (m_state == S_DOOR) begin
                if (call_valid && call_floor == current_floor) begin
                    ndoor = DC;
                end else begin
                    if (call_valid) np[call_floor] = 1'b1;
                    if (door_hold) ndoor = DC;
                    else if (m_door <= 1) ns = S_IDLE;
                    else ndoor = m_door - 1;
                end
            end else begin
                if (call_valid) np[call_floor] = 1'b1;
                ns = S_IDLE;
            end
            m_state <= ns;
            m_pend  <= np;
            m_dir   <= nd;
            m_door  <= ndoor;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : cmp
        logic [15:0] exp_v, act_v;
        exp_v = {m_state, m_state == S_UP, m_state == S_DN, m_state == S_DOOR,
                 (m_state == S_IDLE || m_state == S_DOOR || m_state == S_EMG), m_dir, m_pend};
        act_v = {state, move_up, move_down, door_open, stopped, direction, pending};
        n_checks++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL model_cycle t=%0t got %h expected %h", $time, act_v, exp_v);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_call(input logic [2:0] f);
        call_valid = 1'b1;
        call_floor = f;
        tick(1);
        call_valid = 1'b0;
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            tick(1);
            k++;
        end
        check(name, state, s);
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (door_open === 1'b1 && n < 100) begin
            n++;
            tick(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        call_valid = 0; call_floor = 0; current_floor = 3'd2; floor_valid = 1;
        emergency_stop = 0; door_hold = 0; c6_valid = 0; c6_floor = 0;
        tick(2);
        check("reset_state", {state, move_up, move_down, door_open, stopped}, {S_IDLE, 4'b0001});
        check("reset_pending_dir", {pending, direction}, {8'h00, 1'b1});
        @(negedge clk) reset = 1'b1;
        tick(1);

        // Floor 2, call 5: pass 3 and 4, stop at 5 with a same-cycle repeat call.
        do_call(3'd5);
        check("call5_pending", pending, 8'h20);
        tick(1);
        check("call5_move_up", {state, move_up}, {S_UP, 1'b1});
        current_floor = 3'd3; tick(1);
        current_floor = 3'd4; tick(1);
        check("pass_no_stop", state, S_UP);
        current_floor = 3'd5; call_valid = 1; call_floor = 3'd5; tick(1);
        call_valid = 0;
        check("stop5_clear_wins", {state, pending}, {S_DOOR, 8'h00});
        count_door(n);
        check("door_cycles", n, 4);
        check("after_door_idle", state, S_IDLE);

        // Floor 4 heading up, calls 6 and 1: serve 6, reverse, serve 1.
        current_floor = 3'd4;
        do_call(3'd6);
        do_call(3'd1);
        check("scan_up_first", {state, direction, pending}, {S_UP, 1'b1, 8'h42});
        current_floor = 3'd5; tick(1);
        current_floor = 3'd6; tick(1);
        check("serve6", {state, direction, pending}, {S_DOOR, 1'b1, 8'h02});
        wait_state("serve6_idle", S_IDLE, 20);
        tick(1);
        check("reverse_down", {state, direction, move_down}, {S_DN, 1'b0, 1'b1});
        for (int f = 5; f >= 1; f--) begin
            current_floor = 3'(f);
            tick(1);
        end
        check("serve1", {state, pending}, {S_DOOR, 8'h00});
        wait_state("serve1_idle", S_IDLE, 20);

        // Emergency while heading for 7; a call logged during it is kept.
        do_call(3'd7);
        tick(1);
        check("toward7", {state, direction}, {S_UP, 1'b1});
        current_floor = 3'd2; tick(1);
        current_floor = 3'd3; emergency_stop = 1; tick(1);
        check("emg_enter", {state, move_up, move_down, door_open, stopped, pending},
              {S_EMG, 4'b0001, 8'h80});
        do_call(3'd0);
        tick(1);
        check("emg_call_kept", {state, pending}, {S_EMG, 8'h81});
        emergency_stop = 0; tick(1);
        check("emg_release_idle", state, S_IDLE);
        tick(1);
        check("emg_resume_up", state, S_UP);
        for (int f = 4; f <= 7; f++) begin
            current_floor = 3'(f);
            tick(1);
        end
        check("serve7", {state, pending}, {S_DOOR, 8'h01});
        wait_state("serve7_idle", S_IDLE, 20);
        tick(1);
        check("top_reverse", {move_up, move_down, direction}, {1'b0, 1'b1, 1'b0});
        for (int f = 6; f >= 0; f--) begin
            current_floor = 3'(f);
            tick(1);
        end
        check("serve0", {state, pending}, {S_DOOR, 8'h00});
        wait_state("serve0_idle", S_IDLE, 20);

        // Door obstructed for 10 cycles, then a mid-door repeat call.
        do_call(3'd0);
        check("here_call_door", {state, pending}, {S_DOOR, 8'h00});
        door_hold = 1;
        n = 0;
        while (door_open === 1'b1 && n < 100) begin
            n++;
            if (n == 11) door_hold = 0;
            tick(1);
        end
        door_hold = 0;
        check("door_hold_cycles", n, 14);
        do_call(3'd0);
        n = 0;
        while (door_open === 1'b1 && n < 100) begin
            n++;
            if (n == 3) begin
                call_valid = 1;
                call_floor = 3'd0;
            end
            if (n == 4) call_valid = 0;
            tick(1);
        end
        check("door_reload_cycles", n, 7);
        check("door_reload_pending", pending, 8'h00);

        // 6-floor build: calls 7 and 6 are out of range.
        c6_valid = 1; c6_floor = 3'd7; tick(1);
        c6_floor = 3'd6; tick(1);
        c6_valid = 0;
        check("oor_ignored", {state6, pending6}, {S_IDLE, 6'h00});
        c6_valid = 1; c6_floor = 3'd5; tick(1);
        c6_valid = 0;
        check("c6_in_range", pending6, 6'h20);
        tick(1);
        check("c6_move_up", {state6, move_up6, move_down6, door_open6, stopped6, direction6},
              {S_UP, 5'b10001});

        // Asynchronous reset in the middle of a downward run.
        current_floor = 3'd6;
        do_call(3'd5);
        do_call(3'd2);
        floor_valid = 0;
        do_call(3'd0);
        check("pre_reset_run", {state, pending}, {S_DN, 8'h25});
        #2 reset = 1'b0;
        #1;
        check("async_reset", {state, move_up, move_down, door_open, stopped, direction, pending},
              {S_IDLE, 4'b0001, 1'b1, 8'h00});
        check("async_reset6", {state6, pending6}, {S_IDLE, 6'h00});
        @(negedge clk) reset = 1'b1;
        tick(2);
        check("post_reset_idle", {state, pending}, {S_IDLE, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
